// File: rtl/adder_share_arbiter_pkg.sv
// Package for the shared-adder arbiter: default sizes, requester indices and id-width helper.
// Optional signed-overflow output is controlled by macro ADDER_ARB_OVF_EN (see top level).
package adder_share_arbiter_pkg;

    `include "adder_arb_defs.vh"

    // A single requester still needs a 1-bit id so the port never collapses to zero width.
    function automatic int arb_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_arb_defs.vh
// Shared defaults for the adder-sharing arbiter: data width, requester count and requester indices.
// Included inside adder_share_arbiter_pkg so the constants are package-scoped.
`ifndef ADDER_ARB_DEFS_VH
`define ADDER_ARB_DEFS_VH

localparam int ADDER_ARB_WIDTH   = 32;
localparam int ADDER_ARB_NUM_REQ = 3;

localparam int REQ_PC4 = 0;
localparam int REQ_BR  = 1;
localparam int REQ_ALU = 2;

`endif

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping to 0.
// Returns a one-hot grant (gated by enable) and the binary index of the winner.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl_shift;
    logic [NUM_REQ-1:0]   rot;
    logic                 found;
    logic [ID_W:0]        raw_idx;

    // Rotating the doubled vector puts requester ptr at bit 0, so priority is simply lowest bit.
    assign dbl_shift = {valid, valid} >> ptr;
    assign rot       = dbl_shift[NUM_REQ-1:0];

    always_comb begin
        found   = 1'b0;
        raw_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found   = 1'b1;
                raw_idx = {1'b0, ptr} + (ID_W+1)'(k);
            end
        end
        if (raw_idx >= NUM_REQ_W) begin
            raw_idx = raw_idx - NUM_REQ_W;
        end
    end

    assign idx = raw_idx[ID_W-1:0];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = enable && found && (idx == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/adder_share_arbiter.sv
// One registered WIDTH-bit adder shared round-robin among NUM_REQ valid/ready requesters.
// Define ADDER_ARB_OVF_EN to build the signed-overflow flag; otherwise rsp_ovf is tied to 0.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter  int WIDTH   = ADDER_ARB_WIDTH,
    parameter  int NUM_REQ = ADDER_ARB_NUM_REQ,
    localparam int ID_W    = arb_id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    input  logic [NUM_REQ*WIDTH-1:0] req_in2,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic                     rsp_ovf
);

    logic              rsp_valid_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    logic [WIDTH-1:0]  rsp_sum_reg;
    logic              rsp_carry_reg;
    logic [ID_W-1:0]   rr_ptr_reg;

    logic              slot_free;
    logic              pick_enable;
    logic              accept;
    logic [ID_W-1:0]   pick_idx;
    logic [WIDTH-1:0]  in1_arr [NUM_REQ];
    logic [WIDTH-1:0]  in2_arr [NUM_REQ];
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH:0]    full_sum;

    // The result slot can take a new value if it is empty or being drained this cycle.
    assign slot_free   = !rsp_valid_reg || rsp_ready;
    assign pick_enable = slot_free && !reset;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .valid  (req_valid),
        .ptr    (rr_ptr_reg),
        .enable (pick_enable),
        .grant  (req_ready),
        .idx    (pick_idx)
    );

    assign accept = |(req_valid & req_ready);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign in1_arr[gi] = req_in1[gi*WIDTH +: WIDTH];
            assign in2_arr[gi] = req_in2[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign op_a     = in1_arr[pick_idx];
    assign op_b     = in2_arr[pick_idx];
    assign full_sum = {1'b0, op_a} + {1'b0, op_b};

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_sum_reg   <= '0;
            rsp_carry_reg <= 1'b0;
            rr_ptr_reg    <= '0;
        end else if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= pick_idx;
            rsp_sum_reg   <= full_sum[WIDTH-1:0];
            rsp_carry_reg <= full_sum[WIDTH];
            rr_ptr_reg    <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

`ifdef ADDER_ARB_OVF_EN
    logic ovf_next;
    logic rsp_ovf_reg;

    // Overflow: operands share a sign that the truncated sum does not.
    assign ovf_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (full_sum[WIDTH-1] != op_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_ovf_reg <= 1'b0;
        end else if (accept) begin
            rsp_ovf_reg <= ovf_next;
        end
    end

    assign rsp_ovf = rsp_ovf_reg;
`else
    assign rsp_ovf = 1'b0;
`endif

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_carry = rsp_carry_reg;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized bench for adder_share_arbiter against a queue-free behavioural model of the
// arbitration and add rules; directed cases first, then random traffic with backpressure and resets.
module tb_adder_share_arbiter;
    import adder_share_arbiter_pkg::*;

    localparam int W    = ADDER_ARB_WIDTH;
    localparam int N    = ADDER_ARB_NUM_REQ;
    localparam int ID_W = arb_id_w(N);

    logic             clk;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_in1;
    logic [N*W-1:0]   req_in2;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ID_W-1:0]  rsp_id;
    logic [W-1:0]     rsp_sum;
    logic             rsp_carry;
    logic             rsp_ovf;

    logic [W-1:0] a_arr [N];
    logic [W-1:0] b_arr [N];

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    bit           m_valid = 1'b0;
    int           m_id    = 0;
    logic [W-1:0] m_sum   = '0;
    bit           m_carry = 1'b0;
    bit           m_ovf   = 1'b0;
    int           m_ptr   = 0;

    adder_share_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_ovf   (rsp_ovf)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign req_in1[gi*W +: W] = a_arr[gi];
            assign req_in2[gi*W +: W] = b_arr[gi];
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic step();
        int           g;
        int           j;
        logic [N-1:0] exp_rdy;
        logic [63:0]  full;
        longint       s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        @(negedge clk);
        g = -1;
        if (!reset && (!m_valid || rsp_ready)) begin
            for (int off = 0; off < N; off++) begin
                j = (m_ptr + off) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy = N'(1) << g;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("rsp_id",    64'(rsp_id),    64'(m_id));
        check("rsp_sum",   64'(rsp_sum),   64'(m_sum));
        check("rsp_carry", 64'(rsp_carry), 64'(m_carry));
        check("rsp_ovf",   64'(rsp_ovf),   64'(m_ovf));
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0; m_id = 0; m_sum = '0; m_carry = 1'b0; m_ovf = 1'b0; m_ptr = 0;
        end else if (g >= 0) begin
            a = a_arr[g];
            b = b_arr[g];
            full = {32'b0, a} + {32'b0, b};
            s = longint'($signed(a)) + longint'($signed(b));
            m_valid = 1'b1;
            m_id    = g;
            m_sum   = full[W-1:0];
            m_carry = full[W];
`ifdef ADDER_ARB_OVF_EN
            m_ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`else
            m_ovf   = 1'b0;
`endif
            m_ptr   = (g + 1) % N;
            $display("accept req%0d a=%h b=%h -> sum=%h carry=%0d", g, a, b, m_sum, m_carry);
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '1;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset     = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = W'(i * 16);
            b_arr[i] = W'(i + 1);
        end

        // reset held two cycles with all requests pending
        step();
        step();
        reset     = 1'b0;
        req_valid = '0;
        step();

        // single PC+4 request
        req_valid = '0;
        req_valid[REQ_PC4] = 1'b1;
        a_arr[REQ_PC4] = W'(100);
        b_arr[REQ_PC4] = W'(4);
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        check("t2_sum", 64'(rsp_sum), 64'd104);
        check("t2_id", 64'(rsp_id), 64'd0);
        step();

        // all requesters back-to-back
        req_valid = '1;
        for (int k = 0; k < 6; k++) step();

        // backpressure with the branch requester waiting
        rsp_ready = 1'b0;
        req_valid = '0;
        req_valid[REQ_BR] = 1'b1;
        a_arr[REQ_BR] = 32'h0000_1000;
        b_arr[REQ_BR] = 32'hFFFF_FFF0;
        for (int k = 0; k < 3; k++) step();
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        check("t4_id", 64'(rsp_id), 64'(REQ_BR));
        step();

        // wrap-around and signed overflow on the ALU requester
        req_valid = '0;
        req_valid[REQ_ALU] = 1'b1;
        a_arr[REQ_ALU] = 32'hFFFF_FFFF;
        b_arr[REQ_ALU] = 32'h1;
        step();
        check("t5_wrap_sum", 64'(rsp_sum), 64'd0);
        check("t5_wrap_carry", 64'(rsp_carry), 64'd1);
        a_arr[REQ_ALU] = 32'h7FFF_FFFF;
        step();
`ifdef ADDER_ARB_OVF_EN
        check("t5_ovf", 64'(rsp_ovf), 64'd1);
`else
        check("t5_ovf", 64'(rsp_ovf), 64'd0);
`endif

        // reset right after an accept drops the result
        step();
        req_valid = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_valid_after_reset", 64'(rsp_valid), 64'd0);
        req_valid[REQ_ALU] = 1'b1;
        step();
        check("t6_regrant_id", 64'(rsp_id), 64'(REQ_ALU));
        req_valid = '0;
        step();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                a_arr[i] = pick_operand();
                b_arr[i] = pick_operand();
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;
        req_valid = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
